// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Round-robin arbiter sharing the single write port of the byte FIFO between
// N_REQ producers. A granted producer keeps the port for up to MAX_BURST
// consecutive bytes. When the owner releases (its req drops or its burst is
// used up), a new winner is picked in the same cycle, so no bubble cycle is
// inserted.
//
// Ports
//   clk         clock, all state on posedge
//   rst         synchronous reset, active high
//   req         req[i]=1: producer i offers its byte this cycle
//   req_data    byte i at [8*i+7:8*i]
//   ack         one-hot, ack[i]=1: byte i is written to the FIFO this cycle
//   fifo_full   FIFO full flag
//   fifo_write  FIFO write strobe
//   fifo_wdata  FIFO write data (0 when not writing)
//   diag_state  0=IDLE, 1=LOCKED
//   diag_owner  current/last owner index
//   diag_count  bytes written in the current burst
module fifo_wr_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 4,
  parameter int OWNER_W   = $clog2(N_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  input  logic                 fifo_full,
  output logic                 fifo_write,
  output logic [7:0]           fifo_wdata,
  output logic                 diag_state,
  output logic [OWNER_W-1:0]   diag_owner,
  output logic [CNT_W-1:0]     diag_count
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t             state;
  logic [OWNER_W-1:0] owner;
  logic [CNT_W-1:0]   count;
  logic [OWNER_W-1:0] last;

  logic               cont;
  logic               found;
  logic [OWNER_W-1:0] idx;
  logic [OWNER_W-1:0] scan_sel;
  logic [OWNER_W-1:0] sel;
  logic               valid;

  // The owner keeps the port while it still requests and has burst budget left.
  assign cont = (state == LOCKED) && req[owner] && (count < MAX_CNT);

  // Round-robin scan starting just after the last granted producer; the
  // previous winner is therefore looked at last.
  always_comb begin
    found    = 1'b0;
    scan_sel = '0;
    idx      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = OWNER_W'((int'(last) + i) % N_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        scan_sel = idx;
      end
    end
  end

  assign sel   = cont ? owner : scan_sel;
  assign valid = cont || (|req);

  // Writes are combinational from the registers so a byte is taken in the
  // cycle it is offered; reset suppresses any write in the reset cycle.
  assign fifo_write = valid && !fifo_full && !rst;
  assign fifo_wdata = fifo_write ? req_data[8*sel +: 8] : 8'h00;
  assign ack        = fifo_write ? (N_REQ'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      count <= '0;
      last  <= OWNER_W'(N_REQ - 1);
    end else if (fifo_write) begin
      if (cont) begin
        count <= count + CNT_W'(1);
      end else begin
        owner <= sel;
        count <= CNT_W'(1);
        state <= LOCKED;
      end
      last <= sel;
    end else if (!fifo_full) begin
      // Nobody is requesting: drop the lock but remember who went last.
      state <= IDLE;
      count <= '0;
    end
  end

  assign diag_state = (state == LOCKED);
  assign diag_owner = owner;
  assign diag_count = count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        full = 1'b0;
  logic [1:0]  req2 = '0;
  logic [15:0] data2 = 16'hB1A0;
  logic [1:0]  ack2;
  logic        wr2;
  logic [7:0]  wd2;
  logic        st2;
  logic        ow2;
  logic [2:0]  cn2;
  logic [2:0]  req3 = '0;
  logic [23:0] data3 = 24'hC2B1A0;
  logic [2:0]  ack3;
  logic        wr3;
  logic [7:0]  wd3;
  logic        st3;
  logic [1:0]  ow3;
  logic        cn3;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(2), .MAX_BURST(4)) u2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(data2), .ack(ack2),
    .fifo_full(full), .fifo_write(wr2), .fifo_wdata(wd2),
    .diag_state(st2), .diag_owner(ow2), .diag_count(cn2));

  fifo_wr_arbiter #(.N_REQ(3), .MAX_BURST(1)) u3 (
    .clk(clk), .rst(rst), .req(req3), .req_data(data3), .ack(ack3),
    .fifo_full(full), .fifo_write(wr3), .fifo_wdata(wd3),
    .diag_state(st3), .diag_owner(ow3), .diag_count(cn3));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural reference: who owns the port, how many bytes it has used,
  // and who was granted last. The winner is found by walking producers in
  // order after the last grantee.
  typedef struct {
    bit locked;
    int owner;
    int cnt;
    int last;
  } mst_t;

  function automatic bit bit_at(input logic [2:0] v, input int i);
    return ((v >> i) & 3'd1) != 3'd0;
  endfunction

  function automatic void mdl(input mst_t s, input int n, input int maxb,
                              input logic [2:0] rq, input logic f, input logic rs,
                              output int win, output mst_t ns);
    bit keep;
    ns  = s;
    win = -1;
    if (rs) begin
      ns.locked = 1'b0; ns.owner = 0; ns.cnt = 0; ns.last = n - 1;
      return;
    end
    keep = s.locked && bit_at(rq, s.owner) && (s.cnt < maxb);
    if (keep) win = s.owner;
    else
      for (int k = 1; k <= n; k++)
        if (win < 0 && bit_at(rq, (s.last + k) % n)) win = (s.last + k) % n;
    if (f) begin
      win = -1;
      return;
    end
    if (win < 0) begin
      ns.locked = 1'b0; ns.cnt = 0;
    end else begin
      if (keep) ns.cnt = s.cnt + 1;
      else begin
        ns.owner = win; ns.cnt = 1; ns.locked = 1'b1;
      end
      ns.last = win;
    end
  endfunction

  mst_t m2 = '{1'b0, 0, 0, 1};
  mst_t m3 = '{1'b0, 0, 0, 2};
  mst_t n2 = '{1'b0, 0, 0, 1};
  mst_t n3 = '{1'b0, 0, 0, 2};

  always @(negedge clk) begin
    int w2, w3;
    logic [31:0] e;
    mdl(m2, 2, 4, {1'b0, req2}, full, rst, w2, n2);
    mdl(m3, 3, 1, req3, full, rst, w3, n3);
    if (chk_en) begin
      chk("m2_write", {31'd0, wr2}, (w2 >= 0) ? 32'd1 : 32'd0);
      e = (w2 >= 0) ? (32'd1 << w2) : 32'd0;
      chk("m2_ack", {30'd0, ack2}, e);
      e = (w2 >= 0) ? {24'd0, data2[8*w2 +: 8]} : 32'd0;
      chk("m2_wdata", {24'd0, wd2}, e);
      chk("m2_state", {31'd0, st2}, {31'd0, m2.locked});
      chk("m2_owner", {31'd0, ow2}, m2.owner);
      chk("m2_count", {29'd0, cn2}, m2.cnt);
      chk("m3_write", {31'd0, wr3}, (w3 >= 0) ? 32'd1 : 32'd0);
      e = (w3 >= 0) ? (32'd1 << w3) : 32'd0;
      chk("m3_ack", {29'd0, ack3}, e);
      e = (w3 >= 0) ? {24'd0, data3[8*w3 +: 8]} : 32'd0;
      chk("m3_wdata", {24'd0, wd3}, e);
      chk("m3_state", {31'd0, st3}, {31'd0, m3.locked});
      chk("m3_owner", {30'd0, ow3}, m3.owner);
      chk("m3_count", {31'd0, cn3}, m3.cnt);
    end
  end

  always @(posedge clk) begin
    m2 = n2;
    m3 = n3;
  end

  // Drive one cycle of inputs just after the edge, return mid low phase.
  task automatic step(input logic [1:0] r2, input logic [2:0] r3, input logic f, input logic rs);
    @(posedge clk);
    #1;
    req2 = r2; req3 = r3; full = f; rst = rs;
    @(negedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] a2;
    logic [2:0] a3;

    // Reset, then idle
    step(2'b00, 3'b000, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(2'b00, 3'b000, 1'b0, 1'b1);
    step(2'b00, 3'b000, 1'b0, 1'b0);
    chk("rst_ack", {30'd0, ack2}, 32'd0);
    chk("rst_write", {31'd0, wr2}, 32'd0);
    chk("rst_wdata", {24'd0, wd2}, 32'd0);
    chk("rst_state", {31'd0, st2}, 32'd0);
    chk("rst_owner", {31'd0, ow2}, 32'd0);
    chk("rst_count", {29'd0, cn2}, 32'd0);

    // Both requesting: bursts of four alternate with no idle cycle
    for (int k = 0; k < 12; k++) begin
      step(2'b11, 3'b000, 1'b0, 1'b0);
      chk("rr_ack", {30'd0, ack2}, ((k / 4) % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_wdata", {24'd0, wd2}, ((k / 4) % 2 == 0) ? 32'hA0 : 32'hB1);
    end

    // Owner withdraws after two bytes
    step(2'b00, 3'b000, 1'b0, 1'b1);
    step(2'b11, 3'b000, 1'b0, 1'b0);
    chk("drop_ack0", {30'd0, ack2}, 32'd1);
    step(2'b11, 3'b000, 1'b0, 1'b0);
    chk("drop_ack1", {30'd0, ack2}, 32'd1);
    step(2'b10, 3'b000, 1'b0, 1'b0);
    chk("drop_ack2", {30'd0, ack2}, 32'd2);
    step(2'b10, 3'b000, 1'b0, 1'b0);
    chk("drop_count", {29'd0, cn2}, 32'd1);
    chk("drop_owner", {31'd0, ow2}, 32'd1);

    // FIFO full in the middle of a burst
    step(2'b00, 3'b000, 1'b0, 1'b1);
    step(2'b11, 3'b000, 1'b0, 1'b0);
    step(2'b11, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(2'b11, 3'b000, 1'b1, 1'b0);
      chk("full_ack", {30'd0, ack2}, 32'd0);
      chk("full_count", {29'd0, cn2}, 32'd2);
      chk("full_state", {31'd0, st2}, 32'd1);
    end
    step(2'b11, 3'b000, 1'b0, 1'b0);
    chk("full_after0", {30'd0, ack2}, 32'd1);
    step(2'b11, 3'b000, 1'b0, 1'b0);
    chk("full_after1", {30'd0, ack2}, 32'd1);
    step(2'b11, 3'b000, 1'b0, 1'b0);
    chk("full_after2", {30'd0, ack2}, 32'd2);

    // Single requester: count wraps 4 -> 1 without a gap
    step(2'b00, 3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step(2'b10, 3'b000, 1'b0, 1'b0);
      chk("solo_ack", {30'd0, ack2}, 32'd2);
      chk("solo_count", {29'd0, cn2}, (k == 0) ? 32'd0 : ((k - 1) % 4 + 1));
    end

    // Reset mid-burst
    step(2'b00, 3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(2'b10, 3'b000, 1'b0, 1'b0);
    step(2'b11, 3'b000, 1'b0, 1'b1);
    chk("midrst_write", {31'd0, wr2}, 32'd0);
    chk("midrst_ack", {30'd0, ack2}, 32'd0);
    chk("midrst_cnt_before", {29'd0, cn2}, 32'd3);
    step(2'b11, 3'b000, 1'b0, 1'b0);
    chk("midrst_state", {31'd0, st2}, 32'd0);
    chk("midrst_count", {29'd0, cn2}, 32'd0);
    chk("midrst_ack1", {30'd0, ack2}, 32'd1);

    // Three producers, bursts of one: pure per-byte round robin
    step(2'b00, 3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(2'b00, 3'b111, 1'b0, 1'b0);
      chk("rr3_ack", {29'd0, ack3}, 32'd1 << (k % 3));
      chk("rr3_wdata", {24'd0, wd3}, (k % 3 == 0) ? 32'hA0 : (k % 3 == 1) ? 32'hB1 : 32'hC2);
    end

    // Random traffic: a pending byte stays stable until taken or withdrawn
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      a2 = ack2;
      a3 = ack3;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (req2[i] && !a2[i]) begin
          if ($urandom_range(0, 15) == 0) req2[i] = 1'b0;
        end else begin
          req2[i] = ($urandom_range(0, 3) != 0);
          data2[8*i +: 8] = 8'($urandom);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (req3[i] && !a3[i]) begin
          if ($urandom_range(0, 15) == 0) req3[i] = 1'b0;
        end else begin
          req3[i] = ($urandom_range(0, 2) != 0);
          data3[8*i +: 8] = 8'($urandom);
        end
      end
      full = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
